change_dispenser: RTL
=====================

# change_dispenser

Downstream stage of the vending machine controller. It consumes the stream of change-denomination codes (`change_code` / `change_valid` / `no_change`) and buffers them in a FIFO, because the controller emits up to one code per clock with no backpressure. It drives the coin hopper one coin at a time (eject pulse, then wait for the exit sensor) and reports jams, overflow and batch completion back to system control.

## Interface
Parameters:
- FIFO_DEPTH, 16 — change-code FIFO entries; power of two, ≥2
- PULSE_CYCLES, 4 — cycles `o_eject_pulse` stays high per attempt; ≥1
- TIMEOUT_CYCLES, 1000 — cycles to wait for `i_coin_sensed` after each pulse; ≥1
- RETRY_MAX, 2 — re-pulses allowed after the first timeout before declaring a jam

Ports:
- `i_clk` input 1 — system clock, all logic on rising edge
- `i_rst_n` input 1 — asynchronous, active-low reset
- `i_change_code` input 4 — denomination code 1..15, from controller
- `i_change_valid` input 1 — code valid this cycle
- `i_no_change` input 1 — controller cannot make change (qualified by `i_change_valid`)
- `i_coin_sensed` input 1 — hopper exit sensor, synchronous, high ≥1 cycle per coin
- `i_jam_clear` input 1 — operator clears jam (level, sampled each cycle)
- `o_eject_code` output 4 — denomination to eject; 0 when not pulsing
- `o_eject_pulse` output 1 — hopper actuator strobe
- `o_busy` output 1 — FIFO non-empty or FSM not IDLE
- `o_fifo_full` output 1 — FIFO holds FIFO_DEPTH entries
- `o_overflow` output 1 — sticky: a valid code was dropped
- `o_no_change_alarm` output 1 — sticky: controller reported no change
- `o_jam` output 1 — hopper jammed, dispensing halted
- `o_done` output 1 — one-cycle pulse: last buffered coin dispensed
- `o_coins_dispensed` output 16 — total coins confirmed by sensor; wraps 65535→0

## Operation
- Push: on `i_change_valid=1`, `i_no_change=0`, code≠0 and FIFO not full (full evaluated before the edge), write code. If full, drop the code and set `o_overflow`. A push into a full FIFO is dropped even when a pop happens the same cycle.
- `i_change_valid=1` with `i_no_change=1`: set `o_no_change_alarm`, no push. Code 0 with valid: ignored.
- Sticky flags are cleared only by reset.
- FSM states: IDLE, PULSE, WAIT_SENSE, JAM.
  - IDLE: FIFO non-empty → PULSE; load head code into `o_eject_code`, retry count = 0.
  - PULSE: `o_eject_pulse=1` for exactly PULSE_CYCLES cycles → WAIT_SENSE, timeout counter = 0.
  - WAIT_SENSE: `i_coin_sensed=1` → pop head, increment `o_coins_dispensed`, go to IDLE.
    - Timeout counter reaching TIMEOUT_CYCLES with retry count < RETRY_MAX → increment retry count, go to PULSE with the same code.
    - Timeout with retry count = RETRY_MAX → go to JAM.
  - JAM: `o_jam=1`, no pulses, FIFO keeps its contents and pushes still accepted. `i_jam_clear=1` → PULSE with the same head code, retry count = 0.
- `i_coin_sensed` outside WAIT_SENSE is ignored.
- `o_done`: pulsed for the cycle after a pop that leaves the FIFO empty with no push that cycle.
- Pointers use log2(FIFO_DEPTH) bits and wrap naturally. Occupancy counter is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset (async assert): FIFO empty, state IDLE, counters 0. All outputs 0: `o_eject_code`, `o_eject_pulse`, `o_busy`, `o_fifo_full`, `o_overflow`, `o_no_change_alarm`, `o_jam`, `o_done`, `o_coins_dispensed`.
- Reset mid-dispense: pulse drops immediately and buffered codes are lost.
- Latency: code presented in cycle c (idle, empty FIFO) → `o_eject_pulse` and `o_eject_code` high in cycles c+2 .. c+1+PULSE_CYCLES.
- Sensor sampled in cycle s in WAIT_SENSE → pop, counter update and IDLE at the end of s. Next pulse starts at s+2.
- Timeout: the WAIT_SENSE cycle count equals TIMEOUT_CYCLES, then re-pulse or JAM the next cycle.
- All outputs are registered.
- `o_fifo_full` and `o_busy` reflect state after the edge.

## Test plan
- Single coin: push code 3, sensor 2 cycles after pulse ends → pulse cycles c+2..c+5 with code 3, `o_coins_dispensed`=1, `o_done` one cycle, `o_busy`=0 after.
- Burst: push codes 1,2,9,15 on consecutive cycles, sensor answered each time → ejects 1,2,9,15 in order, count=4, single `o_done` after the last.
- Overflow: 17 consecutive pushes with sensor held low → first 16 stored, `o_fifo_full`=1, 17th dropped, `o_overflow`=1 and stays 1.
- Jam: push code 5, never sense → 3 pulses (1+RETRY_MAX) separated by 1000-cycle waits, then `o_jam`=1. Assert `i_jam_clear`, sense → code 5 ejected, count=1, `o_jam`=0.
- No change: valid with `i_no_change`=1 and code 0 → `o_no_change_alarm`=1, FIFO unchanged, no pulse.
- Async reset during PULSE with 3 entries queued → all outputs 0 immediately, no further pulses after release.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: buffers change-denomination codes from the vending
// controller in a FIFO and drives the coin hopper one coin at a time. For
// each coin it sends an eject pulse, waits for the exit sensor, and retries
// on timeout. It reports jams, dropped codes and batch completion.
module change_dispenser #(
    parameter int FIFO_DEPTH     = 16,
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int RETRY_MAX      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_change_code,
    input  logic        i_change_valid,
    input  logic        i_no_change,
    input  logic        i_coin_sensed,
    input  logic        i_jam_clear,
    output logic [3:0]  o_eject_code,
    output logic        o_eject_pulse,
    output logic        o_busy,
    output logic        o_fifo_full,
    output logic        o_overflow,
    output logic        o_no_change_alarm,
    output logic        o_jam,
    output logic        o_done,
    output logic [15:0] o_coins_dispensed
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(PULSE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RW = $clog2(RETRY_MAX + 1) + 1;

    typedef enum logic [1:0] {IDLE, PULSE, WAIT_SENSE, JAM} state_t;

    logic [3:0]    fifo_mem [FIFO_DEPTH];
    logic [3:0]    head_code;
    logic          code_ok, push, pop;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [3:0]    eject_code_q, eject_code_d;
    logic          eject_pulse_q, eject_pulse_d;
    logic          busy_q, busy_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          alarm_q, alarm_d;
    logic          jam_q, jam_d;
    logic          done_q, done_d;
    logic [15:0]   coins_q, coins_d;

    assign head_code = fifo_mem[rd_ptr_q];

    // FIFO storage: written on an accepted push, no reset needed since occupancy guards reads
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_change_code;
        end
    end

    // Next-state logic for the FIFO bookkeeping, sticky flags and the hopper FSM
    always_comb begin
        code_ok = i_change_valid && !i_no_change && (i_change_code != 4'd0);
        push    = code_ok && (count_q != CW'(FIFO_DEPTH));
        pop     = (state_q == WAIT_SENSE) && i_coin_sensed;

        wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d       = count_q + CW'(push) - CW'(pop);
        overflow_d    = overflow_q || (code_ok && (count_q == CW'(FIFO_DEPTH)));
        alarm_d       = alarm_q || (i_change_valid && i_no_change);
        done_d        = pop && (count_q == CW'(1)) && !push;

        state_d       = state_q;
        pulse_cnt_d   = pulse_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        retry_d       = retry_q;
        eject_code_d  = eject_code_q;
        eject_pulse_d = eject_pulse_q;
        jam_d         = jam_q;
        coins_d       = coins_q;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d       = PULSE;
                    eject_code_d  = head_code;
                    eject_pulse_d = 1'b1;
                    pulse_cnt_d   = '0;
                    retry_d       = '0;
                end
            end
            PULSE: begin
                if (pulse_cnt_q == PW'(PULSE_CYCLES - 1)) begin
                    state_d       = WAIT_SENSE;
                    eject_pulse_d = 1'b0;
                    eject_code_d  = 4'd0;
                    wait_cnt_d    = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PW'(1);
                end
            end
            WAIT_SENSE: begin
                if (i_coin_sensed) begin
                    state_d = IDLE;
                    coins_d = coins_q + 16'd1;
                end else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    if (retry_q < RW'(RETRY_MAX)) begin
                        state_d       = PULSE;
                        retry_d       = retry_q + RW'(1);
                        eject_code_d  = head_code;
                        eject_pulse_d = 1'b1;
                        pulse_cnt_d   = '0;
                    end else begin
                        state_d = JAM;
                        jam_d   = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            JAM: begin
                if (i_jam_clear) begin
                    state_d       = PULSE;
                    jam_d         = 1'b0;
                    retry_d       = '0;
                    eject_code_d  = head_code;
                    eject_pulse_d = 1'b1;
                    pulse_cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (count_d != '0) || (state_d != IDLE);
        full_d = (count_d == CW'(FIFO_DEPTH));
    end

    // Register all state and outputs; reset empties the FIFO and silences the hopper
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            pulse_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            retry_q       <= '0;
            eject_code_q  <= 4'd0;
            eject_pulse_q <= 1'b0;
            busy_q        <= 1'b0;
            full_q        <= 1'b0;
            overflow_q    <= 1'b0;
            alarm_q       <= 1'b0;
            jam_q         <= 1'b0;
            done_q        <= 1'b0;
            coins_q       <= 16'd0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            pulse_cnt_q   <= pulse_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            retry_q       <= retry_d;
            eject_code_q  <= eject_code_d;
            eject_pulse_q <= eject_pulse_d;
            busy_q        <= busy_d;
            full_q        <= full_d;
            overflow_q    <= overflow_d;
            alarm_q       <= alarm_d;
            jam_q         <= jam_d;
            done_q        <= done_d;
            coins_q       <= coins_d;
        end
    end

    assign o_eject_code      = eject_code_q;
    assign o_eject_pulse     = eject_pulse_q;
    assign o_busy            = busy_q;
    assign o_fifo_full       = full_q;
    assign o_overflow        = overflow_q;
    assign o_no_change_alarm = alarm_q;
    assign o_jam             = jam_q;
    assign o_done            = done_q;
    assign o_coins_dispensed = coins_q;

endmodule
